// File: rtl/fpu_exception_responder_if.sv
// Handshake and status bundle between the FPU/CPU side and the exception responder.
interface fpu_exception_responder_if;
    logic       fpu_int;
    logic [5:0] fpu_exc;
    logic       wait_req;
    logic       clex_req;
    logic       clex_nowait;
    logic       irq_ack;
    logic       wait_grant;
    logic       fault;
    logic       clex_done;
    logic       exception_clear;
    logic       irq;
    logic [5:0] exc_snapshot;
    logic [7:0] exc_count;
    logic       busy;

    modport master (
        output fpu_int, fpu_exc, wait_req, clex_req, clex_nowait, irq_ack,
        input  wait_grant, fault, clex_done, exception_clear, irq,
               exc_snapshot, exc_count, busy
    );

    modport slave (
        input  fpu_int, fpu_exc, wait_req, clex_req, clex_nowait, irq_ack,
        output wait_grant, fault, clex_done, exception_clear, irq,
               exc_snapshot, exc_count, busy
    );
endinterface

// File: rtl/fpu_exception_responder.sv
// Routes FPU exception interrupts to the CPU and arbitrates wait-check and
// exception-clear requests from the instruction sequencer.
module fpu_exception_responder (
    input  logic                        clk,
    input  logic                        reset,
    fpu_exception_responder_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE,
        IRQ_PEND,
        SERVICED,
        CLEAR,
        CLEAR_DONE
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       grant_q;
    logic       fault_q;
    logic       grant_next;
    logic       fault_next;
    logic       raise;
    logic       accept;
    logic       responding;
    logic [5:0] snap_q;
    logic [7:0] count_q;

    // A request still held during its own response pulse must not be answered twice.
    assign responding = grant_q | fault_q;

    always_comb begin
        state_next = state;
        grant_next = 1'b0;
        fault_next = 1'b0;
        raise      = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE, IRQ_PEND, SERVICED: begin
                if (!responding && bus.clex_req) begin
                    if (bus.clex_nowait || !bus.fpu_int) begin
                        accept = 1'b1;
                    end else begin
                        fault_next = 1'b1;
                    end
                end else if (!responding && bus.wait_req) begin
                    if (bus.fpu_int) begin
                        fault_next = 1'b1;
                    end else begin
                        grant_next = 1'b1;
                    end
                end

                if (accept) begin
                    state_next = CLEAR;
                end else if (state == IDLE) begin
                    if (bus.fpu_int) begin
                        raise      = 1'b1;
                        state_next = IRQ_PEND;
                    end
                end else if (state == IRQ_PEND) begin
                    if (bus.irq_ack) begin
                        state_next = SERVICED;
                    end else if (!bus.fpu_int) begin
                        state_next = IDLE;
                    end
                end else begin
                    if (!bus.fpu_int) begin
                        state_next = IDLE;
                    end
                end
            end
            CLEAR:      state_next = CLEAR_DONE;
            CLEAR_DONE: state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            grant_q <= 1'b0;
            fault_q <= 1'b0;
            snap_q  <= '0;
            count_q <= '0;
        end else begin
            state   <= state_next;
            grant_q <= grant_next;
            fault_q <= fault_next;
            if (raise) begin
                snap_q <= bus.fpu_exc;
                if (count_q != '1) begin
                    count_q <= count_q + 8'd1;
                end
            end
        end
    end

    // irq and the clear-sequence pulses are pure decodes of the registered state.
    assign bus.irq             = (state == IRQ_PEND);
    assign bus.exception_clear = (state == CLEAR);
    assign bus.clex_done       = (state == CLEAR_DONE);
    assign bus.busy            = (state == CLEAR) || (state == CLEAR_DONE);
    assign bus.wait_grant      = grant_q;
    assign bus.fault           = fault_q;
    assign bus.exc_snapshot    = snap_q;
    assign bus.exc_count       = count_q;

endmodule

// File: tb/tb_fpu_exception_responder.sv
// Self-checking bench: directed vector table, saturation sequence, and a
// randomized run compared against an abstract reference model.
module tb_fpu_exception_responder;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    fpu_exception_responder_if bus();

    fpu_exception_responder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       fi;
        logic [5:0] exc;
        logic       wr;
        logic       cr;
        logic       nw;
        logic       ack;
        logic [5:0] flags;  // {irq, wait_grant, fault, clex_done, exception_clear, busy}
        logic [5:0] snap;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[23];

    // Reference model: irq level, acknowledged flag, clear countdown, pending pulses.
    logic m_irq;
    logic m_acked;
    int   m_clr;
    logic m_grant;
    logic m_fault;
    logic [5:0] m_snap;
    int   m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic fi, input logic [5:0] exc,
                         input logic wr, input logic cr, input logic nw, input logic ack);
        reset           = r;
        bus.fpu_int     = fi;
        bus.fpu_exc     = exc;
        bus.wait_req    = wr;
        bus.clex_req    = cr;
        bus.clex_nowait = nw;
        bus.irq_ack     = ack;
    endtask

    function automatic logic [19:0] actual_out();
        return {bus.irq, bus.wait_grant, bus.fault, bus.clex_done, bus.exception_clear,
                bus.busy, bus.exc_snapshot, bus.exc_count};
    endfunction

    function automatic logic [19:0] model_out();
        logic [7:0] c;
        c = m_cnt[7:0];
        return {m_irq, m_grant, m_fault, (m_clr == 1), (m_clr == 2), (m_clr > 0), m_snap, c};
    endfunction

    task automatic model_reset();
        m_irq = 0; m_acked = 0; m_clr = 0; m_grant = 0; m_fault = 0; m_snap = '0; m_cnt = 0;
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_step();
        logic blocked;
        logic accept;
        logic ng;
        logic nf;
        if (reset) begin
            model_reset();
            return;
        end
        blocked = m_grant | m_fault;
        ng = 0;
        nf = 0;
        accept = 0;
        if (m_clr > 0) begin
            m_clr = m_clr - 1;
        end else begin
            if (!blocked && bus.clex_req) begin
                if (bus.clex_nowait || !bus.fpu_int) accept = 1; else nf = 1;
            end else if (!blocked && bus.wait_req) begin
                if (bus.fpu_int) nf = 1; else ng = 1;
            end
            if (accept) begin
                m_clr = 2; m_irq = 0; m_acked = 0;
            end else if (!m_irq && !m_acked) begin
                if (bus.fpu_int) begin
                    m_irq = 1;
                    m_snap = bus.fpu_exc;
                    if (m_cnt < 255) m_cnt = m_cnt + 1;
                end
            end else if (m_irq) begin
                if (bus.irq_ack) begin
                    m_irq = 0; m_acked = 1;
                end else if (!bus.fpu_int) begin
                    m_irq = 0;
                end
            end else if (!bus.fpu_int) begin
                m_acked = 0;
            end
        end
        m_grant = ng;
        m_fault = nf;
    endtask

    initial begin
        logic [5:0] e;
        logic wr_n;
        logic cr_n;
        logic nw_n;
        logic fi_n;
        n_tests = 0;
        n_fail  = 0;

        //               rst   fi    exc    wr    cr    nw    ack   flags       snap   cnt
        tbl[0]  = '{1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 6'h00, 8'd0};
        tbl[1]  = '{1'b0, 1'b1, 6'h04, 1'b0, 1'b0, 1'b0, 1'b0, 6'b100000, 6'h04, 8'd1};
        tbl[2]  = '{1'b0, 1'b1, 6'h04, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000000, 6'h04, 8'd1};
        tbl[3]  = '{1'b0, 1'b1, 6'h04, 1'b0, 1'b1, 1'b0, 1'b0, 6'b001000, 6'h04, 8'd1};
        tbl[4]  = '{1'b0, 1'b1, 6'h04, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 6'h04, 8'd1};
        tbl[5]  = '{1'b0, 1'b1, 6'h04, 1'b0, 1'b1, 1'b1, 1'b0, 6'b000011, 6'h04, 8'd1};
        tbl[6]  = '{1'b0, 1'b1, 6'h04, 1'b0, 1'b1, 1'b1, 1'b0, 6'b000101, 6'h04, 8'd1};
        tbl[7]  = '{1'b0, 1'b1, 6'h04, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 6'h04, 8'd1};
        tbl[8]  = '{1'b0, 1'b1, 6'h01, 1'b0, 1'b0, 1'b0, 1'b0, 6'b100000, 6'h01, 8'd2};
        tbl[9]  = '{1'b0, 1'b0, 6'h01, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 6'h01, 8'd2};
        tbl[10] = '{1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 6'b010000, 6'h01, 8'd2};
        tbl[11] = '{1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000, 6'h01, 8'd2};
        tbl[12] = '{1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 6'h01, 8'd2};
        tbl[13] = '{1'b0, 1'b1, 6'h02, 1'b1, 1'b0, 1'b0, 1'b0, 6'b101000, 6'h02, 8'd3};
        tbl[14] = '{1'b0, 1'b1, 6'h02, 1'b0, 1'b0, 1'b0, 1'b0, 6'b100000, 6'h02, 8'd3};
        tbl[15] = '{1'b0, 1'b1, 6'h02, 1'b1, 1'b1, 1'b1, 1'b0, 6'b000011, 6'h02, 8'd3};
        tbl[16] = '{1'b0, 1'b0, 6'h02, 1'b1, 1'b1, 1'b1, 1'b0, 6'b000101, 6'h02, 8'd3};
        tbl[17] = '{1'b0, 1'b0, 6'h02, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000, 6'h02, 8'd3};
        tbl[18] = '{1'b0, 1'b0, 6'h02, 1'b1, 1'b0, 1'b0, 1'b0, 6'b010000, 6'h02, 8'd3};
        tbl[19] = '{1'b0, 1'b0, 6'h02, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 6'h02, 8'd3};
        tbl[20] = '{1'b0, 1'b0, 6'h02, 1'b0, 1'b1, 1'b0, 1'b0, 6'b000011, 6'h02, 8'd3};
        tbl[21] = '{1'b1, 1'b0, 6'h02, 1'b0, 1'b1, 1'b0, 1'b0, 6'b000000, 6'h00, 8'd0};
        tbl[22] = '{1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 6'h00, 8'd0};

        drive(1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].fi, tbl[i].exc, tbl[i].wr, tbl[i].cr, tbl[i].nw, tbl[i].ack);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), {12'h0, actual_out()},
                  {12'h0, tbl[i].flags, tbl[i].snap, tbl[i].cnt});
        end

        // Saturation: 260 raise/drop pairs, exc_count must stick at 255.
        for (int k = 1; k <= 260; k++) begin
            e = 6'(k);
            @(negedge clk);
            drive(1'b0, 1'b1, e, 1'b0, 1'b0, 1'b0, 1'b0);
            @(posedge clk);
            #1;
            if (k == 1 || k == 254 || k == 255 || k == 256 || k == 260) begin
                check($sformatf("sat_cnt%0d", k), {24'h0, bus.exc_count},
                      (k < 255) ? k : 255);
                check($sformatf("sat_snap%0d", k), {26'h0, bus.exc_snapshot}, {26'h0, e});
            end
            @(negedge clk);
            drive(1'b0, 1'b0, e, 1'b0, 1'b0, 1'b0, 1'b0);
            @(posedge clk);
        end

        // Randomized run against the reference model.
        @(negedge clk);
        drive(1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        model_reset();
        #1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            fi_n = ($urandom_range(0, 5) == 0) ? ~bus.fpu_int : bus.fpu_int;
            wr_n = bus.wait_req;
            cr_n = bus.clex_req;
            nw_n = bus.clex_nowait;
            if (bus.wait_req && (m_grant || (m_fault && !bus.clex_req))) wr_n = 1'b0;
            else if (!bus.wait_req && $urandom_range(0, 4) == 0) wr_n = 1'b1;
            if (bus.clex_req && (m_clr == 1 || m_fault)) cr_n = 1'b0;
            else if (!bus.clex_req && $urandom_range(0, 7) == 0) begin
                cr_n = 1'b1;
                nw_n = 1'($urandom_range(0, 1));
            end
            drive(($urandom_range(0, 99) == 0), fi_n, 6'($urandom), wr_n, cr_n, nw_n,
                  ($urandom_range(0, 3) == 0));
            @(posedge clk);
            model_step();
            #1;
            check("rand_out", {12'h0, actual_out()}, {12'h0, model_out()});
            check("one_pulse", 32'(int'(bus.wait_grant) + int'(bus.fault) + int'(bus.clex_done) <= 1), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
